// File: rtl/lif_pkg.sv
// Shared types and default constants for the LIF array scheduler.
package lif_pkg;

  typedef logic [7:0] lif_val_t;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } sched_state_e;

  localparam lif_val_t THRESHOLD_DEF     = 8'd128;
  localparam lif_val_t THRESHOLD_INC_DEF = 8'd5;
  localparam lif_val_t THRESHOLD_DEC_DEF = 8'd1;
  localparam lif_val_t THRESHOLD_MIN_DEF = 8'd75;

  function automatic lif_val_t sat_add8(lif_val_t a, lif_val_t b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/lif_array_scheduler_if.sv
// Input-current write channel of the LIF array scheduler.
// A write transfers on a rising clock edge where cur_valid_i and cur_ready_o are both high;
// while valid is high and ready low the producer holds idx/val stable.
interface lif_array_scheduler_if #(
  parameter int IDX_W = 3
) ();
  logic             cur_valid_i;
  logic             cur_ready_o;
  logic [IDX_W-1:0] cur_idx_i;
  logic [7:0]       cur_val_i;

  modport master (output cur_valid_i, output cur_idx_i, output cur_val_i, input cur_ready_o);
  modport slave  (input cur_valid_i, input cur_idx_i, input cur_val_i, output cur_ready_o);
endinterface

// File: rtl/lif_update_core.sv
// Combinational single-neuron LIF update: leak, integrate, fire, and (with
// LIF_ADAPT_EN) adaptive threshold with saturation and floor clamping.
module lif_update_core
  import lif_pkg::*;
#(
`ifdef LIF_ADAPT_EN
  parameter lif_val_t THRESHOLD_INC = THRESHOLD_INC_DEF,
  parameter lif_val_t THRESHOLD_DEC = THRESHOLD_DEC_DEF,
  parameter lif_val_t THRESHOLD_MIN = THRESHOLD_MIN_DEF
`endif
) (
  input  lif_val_t state,
  input  lif_val_t acc,
  input  lif_val_t thr,
  output lif_val_t state_nxt,
`ifdef LIF_ADAPT_EN
  output lif_val_t thr_nxt,
`endif
  output logic     spike
);

  lif_val_t sum;

  always_comb begin
    sum       = sat_add8(acc, state >> 1);
    spike     = (sum >= thr);
    state_nxt = spike ? '0 : sum;
  end

`ifdef LIF_ADAPT_EN
  always_comb begin
    thr_nxt = thr;
    if (spike) begin
      thr_nxt = sat_add8(thr, THRESHOLD_INC);
    end else if (thr > THRESHOLD_MIN) begin
      thr_nxt = ((thr - THRESHOLD_MIN) > THRESHOLD_DEC) ? (thr - THRESHOLD_DEC) : THRESHOLD_MIN;
    end
  end
`endif

endmodule

// File: rtl/lif_array_scheduler.sv
// Sweeps N_NEURONS virtual LIF neurons through one shared update core per tick.
// Define LIF_ADAPT_EN for per-neuron adaptive thresholds; otherwise thr is the constant THRESHOLD.
module lif_array_scheduler
  import lif_pkg::*;
#(
  parameter int       N_NEURONS = 8,
  parameter int       IDX_W     = $clog2(N_NEURONS),
  parameter lif_val_t THRESHOLD = THRESHOLD_DEF
`ifdef LIF_ADAPT_EN
  ,
  parameter lif_val_t THRESHOLD_INC = THRESHOLD_INC_DEF,
  parameter lif_val_t THRESHOLD_DEC = THRESHOLD_DEC_DEF,
  parameter lif_val_t THRESHOLD_MIN = THRESHOLD_MIN_DEF
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_i,
  lif_array_scheduler_if.slave cur_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tick_miss_o,
  output logic [N_NEURONS-1:0] spikes_o,
  input  logic [IDX_W-1:0]     dbg_idx_i,
  output lif_val_t             dbg_state_o,
  output lif_val_t             dbg_thr_o,
  output sched_state_e         dbg_fsm_o
);

  sched_state_e         fsm_q, fsm_d;
  logic [IDX_W-1:0]     idx_q;
  lif_val_t             state_q [N_NEURONS];
  lif_val_t             acc_q   [N_NEURONS];
  logic [N_NEURONS-1:0] spike_vec_q, spike_vec_nxt, spikes_q;
  logic                 miss_q;
  logic                 sweep, last, hs;
  lif_val_t             thr_cur, state_nxt;
  logic                 spike;

  assign sweep = (fsm_q == SWEEP);
  assign last  = (idx_q == IDX_W'(N_NEURONS - 1));
  assign hs    = cur_if.cur_valid_i && cur_if.cur_ready_o;

  assign cur_if.cur_ready_o = !sweep;
  assign busy_o      = (fsm_q != IDLE);
  assign done_o      = (fsm_q == DONE);
  assign tick_miss_o = miss_q;
  assign spikes_o    = spikes_q;
  assign dbg_state_o = state_q[dbg_idx_i];
  assign dbg_fsm_o   = fsm_q;

`ifdef LIF_ADAPT_EN
  lif_val_t thr_q [N_NEURONS];
  lif_val_t thr_nxt;

  assign thr_cur   = thr_q[idx_q];
  assign dbg_thr_o = thr_q[dbg_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_NEURONS; i++) thr_q[i] <= THRESHOLD;
    end else if (sweep) begin
      thr_q[idx_q] <= thr_nxt;
    end
  end
`else
  assign thr_cur   = THRESHOLD;
  assign dbg_thr_o = THRESHOLD;
`endif

  lif_update_core #(
`ifdef LIF_ADAPT_EN
    .THRESHOLD_INC (THRESHOLD_INC),
    .THRESHOLD_DEC (THRESHOLD_DEC),
    .THRESHOLD_MIN (THRESHOLD_MIN)
`endif
  ) u_core (
    .state     (state_q[idx_q]),
    .acc       (acc_q[idx_q]),
    .thr       (thr_cur),
    .state_nxt (state_nxt),
`ifdef LIF_ADAPT_EN
    .thr_nxt   (thr_nxt),
`endif
    .spike     (spike)
  );

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (tick_i) fsm_d = SWEEP;
      SWEEP:   if (last) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    spike_vec_nxt        = spike_vec_q;
    spike_vec_nxt[idx_q] = spike;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q       <= IDLE;
      idx_q       <= '0;
      spike_vec_q <= '0;
      spikes_q    <= '0;
      miss_q      <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      miss_q <= tick_i && (fsm_q != IDLE);
      // idx wraps back to 0 after the last neuron since N_NEURONS is a power of two
      if (sweep) begin
        idx_q       <= idx_q + 1'b1;
        spike_vec_q <= spike_vec_nxt;
        if (last) spikes_q <= spike_vec_nxt;
      end
    end
  end

  // Writes are blocked during SWEEP, so they never collide with the acc clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        acc_q[i]   <= '0;
      end
    end else if (sweep) begin
      state_q[idx_q] <= state_nxt;
      acc_q[idx_q]   <= '0;
    end else if (hs) begin
      acc_q[cur_if.cur_idx_i] <= sat_add8(acc_q[cur_if.cur_idx_i], cur_if.cur_val_i);
    end
  end

endmodule

// File: tb/tb_lif_array_scheduler.sv
// Directed bench for lif_array_scheduler; done_o-driven scoreboard checks spikes_o and latency.
module tb_lif_array_scheduler;
  import lif_pkg::*;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           tick_i = 1'b0;
  logic           busy_o, done_o, tick_miss_o;
  logic [N-1:0]   spikes_o;
  logic [IDX_W-1:0] dbg_idx_i = '0;
  lif_val_t       dbg_state_o, dbg_thr_o;
  sched_state_e   dbg_fsm_o;

  lif_array_scheduler_if #(.IDX_W(IDX_W)) cur_if ();

  lif_array_scheduler #(.N_NEURONS(N)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tick_i      (tick_i),
    .cur_if      (cur_if),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .tick_miss_o (tick_miss_o),
    .spikes_o    (spikes_o),
    .dbg_idx_i   (dbg_idx_i),
    .dbg_state_o (dbg_state_o),
    .dbg_thr_o   (dbg_thr_o),
    .dbg_fsm_o   (dbg_fsm_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks = 0, n_fail = 0, n_done = 0, n_miss = 0;
  logic [N-1:0] exp_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int thr_exp(input int adapt_val);
`ifdef LIF_ADAPT_EN
    return adapt_val;
`else
    return 128;
`endif
  endfunction

  // monitor
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (tick_miss_o) n_miss++;
      if (done_o) begin
        n_done++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done_o with spikes_o=0x%0h, required no done_o at cycle %0d", spikes_o, cyc);
        end else begin
          logic [N-1:0] e;
          int           c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("spikes", spikes_o, e);
          if (c >= 0) check("done_latency", cyc, c);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic write_cur(input int idx, input int val);
    int b = 0;
    cur_if.cur_valid_i = 1'b1;
    cur_if.cur_idx_i   = IDX_W'(idx);
    cur_if.cur_val_i   = 8'(val);
    while (!cur_if.cur_ready_o && b < 50) begin
      step();
      b++;
    end
    check("write_ready_wait", 32'(b < 50), 1);
    step();
    cur_if.cur_valid_i = 1'b0;
  endtask

  task automatic do_tick(input logic [N-1:0] exp, input bit chk_lat);
    exp_q.push_back(exp);
    exp_cyc_q.push_back(chk_lat ? cyc + N + 1 : -1);
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
  endtask

  task automatic tick_write(input int idx, input int val, input logic [N-1:0] exp);
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + N + 1);
    tick_i             = 1'b1;
    cur_if.cur_valid_i = 1'b1;
    cur_if.cur_idx_i   = IDX_W'(idx);
    cur_if.cur_val_i   = 8'(val);
    step();
    tick_i             = 1'b0;
    cur_if.cur_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((busy_o || exp_q.size() != 0) && b < 50) begin
      step();
      b++;
    end
    check("sweep_finish_wait", 32'(b < 50), 1);
  endtask

  task automatic check_dbg(input int idx, input int exp_state, input int exp_thr);
    dbg_idx_i = IDX_W'(idx);
    #1;
    check($sformatf("state[%0d]", idx), dbg_state_o, exp_state);
    check($sformatf("thr[%0d]", idx), dbg_thr_o, exp_thr);
  endtask

  initial begin
    int m0, d0;
    cur_if.cur_valid_i = 1'b0;
    cur_if.cur_idx_i   = '0;
    cur_if.cur_val_i   = '0;

    // 1: reset state
    do_reset();
    check("rst_spikes", spikes_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_miss", tick_miss_o, 0);
    check("rst_ready", cur_if.cur_ready_o, 1);
    check("rst_fsm", dbg_fsm_o, IDLE);
    for (int i = 0; i < N; i++) check_dbg(i, 0, 128);

    // 2: single spike on n3, latency and threshold adaptation
    do_reset();
    write_cur(3, 200);
    do_tick(8'h08, 1'b1);
    wait_idle();
    check("spikes_held", spikes_o, 8'h08);
    check_dbg(3, 0, thr_exp(133));
    for (int i = 0; i < N; i++) if (i != 3) check_dbg(i, 0, thr_exp(127));

    // 3: accumulator saturation and same-cycle tick + write
    do_reset();
    for (int k = 0; k < 3; k++) write_cur(0, 100);
    tick_write(5, 200, 8'h21);
    wait_idle();
    check_dbg(0, 0, thr_exp(133));
    check_dbg(5, 0, thr_exp(133));

    // 4: leak
    do_reset();
    write_cur(1, 100);
    do_tick(8'h00, 1'b1);
    wait_idle();
    check_dbg(1, 100, thr_exp(127));
    do_tick(8'h00, 1'b1);
    wait_idle();
    check_dbg(1, 50, thr_exp(126));

    // 5: dropped tick during sweep
    do_reset();
    m0 = n_miss;
    d0 = n_done;
    write_cur(2, 200);
    do_tick(8'h04, 1'b1);
    step();
    step();
    check("sweep_ready", cur_if.cur_ready_o, 0);
    check("sweep_busy", busy_o, 1);
    check("sweep_fsm", dbg_fsm_o, SWEEP);
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    check("miss_pulse", tick_miss_o, 1);
    step();
    check("miss_clear", tick_miss_o, 0);
    wait_idle();
    repeat (12) step();
    check("miss_count", n_miss - m0, 1);
    check("done_count", n_done - d0, 1);

    // 6: async reset mid-sweep
    do_reset();
    write_cur(2, 200);
    do_tick(8'h04, 1'b1);
    wait_idle();
    check("pre_abort_spikes", spikes_o, 8'h04);
    write_cur(4, 200);
    d0 = n_done;
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    step();
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("abort_spikes", spikes_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_ready", cur_if.cur_ready_o, 1);
    check("abort_fsm", dbg_fsm_o, IDLE);
    check_dbg(2, 0, 128);
    step();
    step();
    rst_ni = 1'b1;
    repeat (15) step();
    check("abort_no_done", n_done - d0, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
